// File: rtl/logic_rs_pkg.sv
// Shared types for the logic/shift reservation station: entry layout, widths and
// the CDB operand-capture helper used by both dispatch bypass and wakeup.
package logic_rs_pkg;
    localparam int WORD_SIZE_P    = 16;
    localparam int WIDTH_OP       = 4;
    localparam int ROB_ENTRY      = 16;
    localparam int NUM_PHYS_REG   = 32;
    localparam int RS_ENTRY_LOGIC = 4;
    localparam int ROB_W          = $clog2(ROB_ENTRY);
    localparam int PREG_W         = $clog2(NUM_PHYS_REG);

    typedef struct packed {
        logic                   rdy;
        logic [PREG_W-1:0]      tag;
        logic [WORD_SIZE_P-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                valid;
        logic [WIDTH_OP-1:0] opcode;
        rs_src_t             src1;
        rs_src_t             src2;
        logic [ROB_W-1:0]    rob_dest;
        logic [PREG_W-1:0]   reg_dest;
    } rs_entry_t;

    // A waiting source whose tag matches the broadcast becomes ready with the result.
    function automatic rs_src_t cdb_snoop(input rs_src_t s, input logic cdb_v,
                                          input logic [PREG_W-1:0] dest,
                                          input logic [WORD_SIZE_P-1:0] res);
        rs_src_t r;
        r = s;
        if (!s.rdy && cdb_v && (s.tag == dest)) begin
            r.rdy = 1'b1;
            r.val = res;
        end
        return r;
    endfunction
endpackage

// File: rtl/rs_age_select.sv
// Age matrix plus oldest-eligible one-hot pick; shared by every FU station.
// age[i][j]=1 means entry j is older than entry i.
module rs_age_select #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic [N-1:0] valid_i,
    input  logic [N-1:0] alloc_i,
    input  logic [N-1:0] eligible_i,
    output logic [N-1:0] grant_o
);
    logic [N-1:0][N-1:0] age, age_nxt;

    // A reallocated slot is the youngest, so its column is cleared in every other row.
    always_comb begin
        age_nxt = age;
        for (int i = 0; i < N; i++) begin
            if (alloc_i[i]) begin
                for (int k = 0; k < N; k++) age_nxt[k][i] = 1'b0;
                age_nxt[i] = valid_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)     age <= '0;
        else if (flush_i) age <= '0;
        else              age <= age_nxt;
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            grant_o[i] = eligible_i[i] && !(|(age[i] & eligible_i));
    end
endmodule

// File: rtl/logic_rs.sv
// Reservation station for the logic/shift FU: holds renamed ops until both
// operands arrive (dispatch or CDB), then issues the oldest ready op per cycle.
module logic_rs
    import logic_rs_pkg::*;
#(
    parameter int RS_ENTRY = RS_ENTRY_LOGIC
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   disp_v_i,
    output logic                   disp_ready_o,
    input  logic [WIDTH_OP-1:0]    disp_opcode_i,
    input  logic                   disp_src1_rdy_i,
    input  logic                   disp_src2_rdy_i,
    input  logic [PREG_W-1:0]      disp_src1_tag_i,
    input  logic [PREG_W-1:0]      disp_src2_tag_i,
    input  logic [WORD_SIZE_P-1:0] disp_src1_val_i,
    input  logic [WORD_SIZE_P-1:0] disp_src2_val_i,
    input  logic [ROB_W-1:0]       disp_rob_dest_i,
    input  logic [PREG_W-1:0]      disp_reg_dest_i,
    input  logic                   cdb_v_i,
    input  logic [PREG_W-1:0]      cdb_dest_i,
    input  logic [WORD_SIZE_P-1:0] cdb_result_i,
    output logic                   exe_v_o,
    output logic [WIDTH_OP-1:0]    opcode_o,
    output logic [WORD_SIZE_P-1:0] operand1_o,
    output logic [WORD_SIZE_P-1:0] operand2_o,
    output logic [ROB_W-1:0]       rob_dest_o,
    output logic [PREG_W-1:0]      reg_dest_o
);
    rs_entry_t            ent [RS_ENTRY];
    rs_entry_t            sel;
    rs_src_t              d_src1, d_src2;
    logic [RS_ENTRY-1:0]  valid, free, alloc, elig, grant;
    logic                 disp_fire, issue;

    always_comb begin
        for (int i = 0; i < RS_ENTRY; i++) begin
            valid[i] = ent[i].valid;
            elig[i]  = ent[i].valid && ent[i].src1.rdy && ent[i].src2.rdy;
        end
    end

    // Readiness looks only at state held at the start of the cycle.
    assign free         = ~valid;
    assign disp_ready_o = |free;
    assign disp_fire    = disp_v_i && disp_ready_o && !flush_i;
    assign alloc        = disp_fire ? (free & (~free + RS_ENTRY'(1))) : '0;
    assign issue        = |grant;

    always_comb begin
        d_src1 = cdb_snoop(rs_src_t'{rdy: disp_src1_rdy_i, tag: disp_src1_tag_i, val: disp_src1_val_i},
                           cdb_v_i, cdb_dest_i, cdb_result_i);
        d_src2 = cdb_snoop(rs_src_t'{rdy: disp_src2_rdy_i, tag: disp_src2_tag_i, val: disp_src2_val_i},
                           cdb_v_i, cdb_dest_i, cdb_result_i);
        sel = '0;
        for (int i = 0; i < RS_ENTRY; i++)
            if (grant[i]) sel = ent[i];
    end

    rs_age_select #(.N(RS_ENTRY)) u_age (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .valid_i    (valid),
        .alloc_i    (alloc),
        .eligible_i (elig),
        .grant_o    (grant)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < RS_ENTRY; i++) ent[i] <= '0;
            exe_v_o    <= 1'b0;
            opcode_o   <= '0;
            operand1_o <= '0;
            operand2_o <= '0;
            rob_dest_o <= '0;
            reg_dest_o <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_ENTRY; i++) ent[i].valid <= 1'b0;
            exe_v_o <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                if (alloc[i]) begin
                    ent[i] <= '{valid: 1'b1, opcode: disp_opcode_i, src1: d_src1, src2: d_src2,
                                rob_dest: disp_rob_dest_i, reg_dest: disp_reg_dest_i};
                end else begin
                    if (grant[i]) ent[i].valid <= 1'b0;
                    ent[i].src1 <= cdb_snoop(ent[i].src1, cdb_v_i, cdb_dest_i, cdb_result_i);
                    ent[i].src2 <= cdb_snoop(ent[i].src2, cdb_v_i, cdb_dest_i, cdb_result_i);
                end
            end
            exe_v_o <= issue;
            if (issue) begin
                opcode_o   <= sel.opcode;
                operand1_o <= sel.src1.val;
                operand2_o <= sel.src2.val;
                rob_dest_o <= sel.rob_dest;
                reg_dest_o <= sel.reg_dest;
            end
        end
    end
endmodule

// File: tb/tb_logic_rs.sv
// Directed bench for logic_rs: issue latency, wakeup, bypass, age order, flush and reset.
module tb_logic_rs;
    import logic_rs_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   reset_i, flush_i, disp_v_i, disp_ready_o;
    logic [WIDTH_OP-1:0]    disp_opcode_i;
    logic                   disp_src1_rdy_i, disp_src2_rdy_i;
    logic [PREG_W-1:0]      disp_src1_tag_i, disp_src2_tag_i;
    logic [WORD_SIZE_P-1:0] disp_src1_val_i, disp_src2_val_i;
    logic [ROB_W-1:0]       disp_rob_dest_i;
    logic [PREG_W-1:0]      disp_reg_dest_i;
    logic                   cdb_v_i;
    logic [PREG_W-1:0]      cdb_dest_i;
    logic [WORD_SIZE_P-1:0] cdb_result_i;
    logic                   exe_v_o;
    logic [WIDTH_OP-1:0]    opcode_o;
    logic [WORD_SIZE_P-1:0] operand1_o, operand2_o;
    logic [ROB_W-1:0]       rob_dest_o;
    logic [PREG_W-1:0]      reg_dest_o;
    int total = 0;
    int bad   = 0;

    logic_rs dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o), .disp_opcode_i(disp_opcode_i),
        .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
        .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
        .disp_src1_val_i(disp_src1_val_i), .disp_src2_val_i(disp_src2_val_i),
        .disp_rob_dest_i(disp_rob_dest_i), .disp_reg_dest_i(disp_reg_dest_i),
        .cdb_v_i(cdb_v_i), .cdb_dest_i(cdb_dest_i), .cdb_result_i(cdb_result_i),
        .exe_v_o(exe_v_o), .opcode_o(opcode_o), .operand1_o(operand1_o),
        .operand2_o(operand2_o), .rob_dest_o(rob_dest_o), .reg_dest_o(reg_dest_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic r1, input logic [4:0] t1,
                        input logic [15:0] v1, input logic r2, input logic [4:0] t2,
                        input logic [15:0] v2, input logic [3:0] rob, input logic [4:0] rg);
        disp_v_i = 1'b1; disp_opcode_i = op;
        disp_src1_rdy_i = r1; disp_src1_tag_i = t1; disp_src1_val_i = v1;
        disp_src2_rdy_i = r2; disp_src2_tag_i = t2; disp_src2_val_i = v2;
        disp_rob_dest_i = rob; disp_reg_dest_i = rg;
    endtask

    task automatic cdb(input logic [4:0] d, input logic [15:0] r);
        cdb_v_i = 1'b1; cdb_dest_i = d; cdb_result_i = r;
    endtask

    task automatic idle();
        disp_v_i = 1'b0; cdb_v_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL rst_exe_v: got %0b want 0", exe_v_o); end
        total++; if (disp_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", disp_ready_o); end
        total++; if (operand1_o !== 16'h0 || rob_dest_o !== 4'h0 || opcode_o !== 4'h0)
            begin bad++; $display("FAIL rst_outs: got op1=%h rob=%h opc=%h want 0", operand1_o, rob_dest_o, opcode_o); end
        reset_i = 1'b1;
        step();
    endtask

    task automatic test_ready();
        disp(4'h1, 1, 0, 16'h00F0, 1, 0, 16'h0FF0, 4'd3, 5'd7);
        step(); idle();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL ready_early: got %0b want 0", exe_v_o); end
        step();
        total++; if (exe_v_o !== 1'b1) begin bad++; $display("FAIL ready_v: got %0b want 1", exe_v_o); end
        total++; if (opcode_o !== 4'h1 || operand1_o !== 16'h00F0 || operand2_o !== 16'h0FF0)
            begin bad++; $display("FAIL ready_ops: got %h %h %h want 1 00f0 0ff0", opcode_o, operand1_o, operand2_o); end
        total++; if (rob_dest_o !== 4'd3 || reg_dest_o !== 5'd7)
            begin bad++; $display("FAIL ready_dest: got rob=%0d reg=%0d want 3 7", rob_dest_o, reg_dest_o); end
        step();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL ready_after: got %0b want 0", exe_v_o); end
        total++; if (operand1_o !== 16'h00F0) begin bad++; $display("FAIL ready_hold: got %h want 00f0", operand1_o); end
    endtask

    task automatic test_wakeup();
        disp(4'h2, 1, 0, 16'h1234, 0, 5'd12, 16'h0, 4'd5, 5'd9);
        step(); idle();
        step(); step();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL wake_wait: got %0b want 0", exe_v_o); end
        cdb(5'd12, 16'h0004);
        step(); idle();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL wake_early: got %0b want 0", exe_v_o); end
        step();
        total++; if (exe_v_o !== 1'b1) begin bad++; $display("FAIL wake_v: got %0b want 1", exe_v_o); end
        total++; if (operand1_o !== 16'h1234 || operand2_o !== 16'h0004 || rob_dest_o !== 4'd5)
            begin bad++; $display("FAIL wake_ops: got %h %h rob=%0d want 1234 0004 5", operand1_o, operand2_o, rob_dest_o); end
        step();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL wake_after: got %0b want 0", exe_v_o); end
    endtask

    task automatic test_bypass();
        disp(4'h3, 0, 5'd5, 16'h0, 1, 0, 16'h0001, 4'd6, 5'd10);
        cdb(5'd5, 16'hBEEF);
        step(); idle();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL byp_early: got %0b want 0", exe_v_o); end
        step();
        total++; if (exe_v_o !== 1'b1 || operand1_o !== 16'hBEEF || operand2_o !== 16'h0001 || rob_dest_o !== 4'd6)
            begin bad++; $display("FAIL byp_issue: got v=%0b %h %h rob=%0d want 1 beef 0001 6", exe_v_o, operand1_o, operand2_o, rob_dest_o); end
        step();
    endtask

    task automatic test_oldest();
        for (int r = 0; r < 4; r++) begin
            total++; if (disp_ready_o !== 1'b1) begin bad++; $display("FAIL old_fill_ready%0d: got %0b want 1", r, disp_ready_o); end
            disp(4'h4, 0, 5'd9, 16'h0, 1, 0, 16'h0010, 4'(r), 5'(r + 16));
            step();
        end
        idle();
        total++; if (disp_ready_o !== 1'b0) begin bad++; $display("FAIL old_full: got %0b want 0", disp_ready_o); end
        cdb(5'd9, 16'h00AA);
        step(); idle();
        total++; if (exe_v_o !== 1'b0 || disp_ready_o !== 1'b0)
            begin bad++; $display("FAIL old_wake: got v=%0b rdy=%0b want 0 0", exe_v_o, disp_ready_o); end
        for (int r = 0; r < 4; r++) begin
            step();
            total++; if (exe_v_o !== 1'b1 || rob_dest_o !== 4'(r) || operand1_o !== 16'h00AA || reg_dest_o !== 5'(r + 16))
                begin bad++; $display("FAIL old_issue%0d: got v=%0b rob=%0d op1=%h reg=%0d", r, exe_v_o, rob_dest_o, operand1_o, reg_dest_o); end
            if (r == 0) begin
                total++; if (disp_ready_o !== 1'b1) begin bad++; $display("FAIL old_ready: got %0b want 1", disp_ready_o); end
            end
        end
        step();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL old_drain: got %0b want 0", exe_v_o); end
    endtask

    // Younger op lands in a lower slot; the older one in a higher slot must still win.
    task automatic test_age_reuse();
        disp(4'h5, 0, 5'd11, 16'h0, 1, 0, 16'h0001, 4'd8, 5'd1);
        step();
        disp(4'h5, 0, 5'd10, 16'h0, 1, 0, 16'h0002, 4'd9, 5'd2);
        step(); idle();
        cdb(5'd11, 16'h0011);
        step(); idle();
        step();
        total++; if (exe_v_o !== 1'b1 || rob_dest_o !== 4'd8)
            begin bad++; $display("FAIL age_first: got v=%0b rob=%0d want 1 8", exe_v_o, rob_dest_o); end
        disp(4'h5, 0, 5'd10, 16'h0, 1, 0, 16'h0003, 4'd10, 5'd3);
        step(); idle();
        cdb(5'd10, 16'h0022);
        step(); idle();
        step();
        total++; if (exe_v_o !== 1'b1 || rob_dest_o !== 4'd9 || operand1_o !== 16'h0022)
            begin bad++; $display("FAIL age_older: got v=%0b rob=%0d op1=%h want 1 9 0022", exe_v_o, rob_dest_o, operand1_o); end
        step();
        total++; if (exe_v_o !== 1'b1 || rob_dest_o !== 4'd10 || operand2_o !== 16'h0003)
            begin bad++; $display("FAIL age_younger: got v=%0b rob=%0d op2=%h want 1 10 0003", exe_v_o, rob_dest_o, operand2_o); end
        step();
    endtask

    task automatic test_flush();
        for (int r = 0; r < 3; r++) begin
            disp(4'h6, 0, 5'd20, 16'h0, 1, 0, 16'h0, 4'(11 + r), 5'd4);
            step();
        end
        disp(4'h7, 1, 0, 16'h5555, 1, 0, 16'h6666, 4'd14, 5'd5);
        flush_i = 1'b1;
        step(); idle();
        total++; if (exe_v_o !== 1'b0 || disp_ready_o !== 1'b1)
            begin bad++; $display("FAIL flush_state: got v=%0b rdy=%0b want 0 1", exe_v_o, disp_ready_o); end
        cdb(5'd20, 16'h7777);
        step(); idle();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL flush_drop1: got %0b want 0", exe_v_o); end
        step();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL flush_drop2: got %0b want 0", exe_v_o); end
    endtask

    task automatic test_reset_mid();
        disp(4'h8, 1, 0, 16'hCAFE, 1, 0, 16'h0, 4'd15, 5'd6);
        step();
        disp(4'h8, 1, 0, 16'hD00D, 1, 0, 16'h0, 4'd1, 5'd6);
        step(); idle();
        total++; if (exe_v_o !== 1'b1 || operand1_o !== 16'hCAFE)
            begin bad++; $display("FAIL rmid_issue: got v=%0b op1=%h want 1 cafe", exe_v_o, operand1_o); end
        #2 reset_i = 1'b0;
        #1;
        total++; if (exe_v_o !== 1'b0 || operand1_o !== 16'h0 || rob_dest_o !== 4'h0 || opcode_o !== 4'h0)
            begin bad++; $display("FAIL rmid_async: got v=%0b op1=%h rob=%0d opc=%h want 0", exe_v_o, operand1_o, rob_dest_o, opcode_o); end
        total++; if (disp_ready_o !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %0b want 1", disp_ready_o); end
        reset_i = 1'b1;
        step();
        total++; if (exe_v_o !== 1'b0) begin bad++; $display("FAIL rmid_discard: got %0b want 0", exe_v_o); end
    endtask

    initial begin
        reset_i = 1'b0;
        disp_opcode_i = '0; disp_src1_rdy_i = 0; disp_src2_rdy_i = 0;
        disp_src1_tag_i = '0; disp_src2_tag_i = '0; disp_src1_val_i = '0; disp_src2_val_i = '0;
        disp_rob_dest_i = '0; disp_reg_dest_i = '0; cdb_dest_i = '0; cdb_result_i = '0;
        idle();
        #12;
        test_reset();
        test_ready();
        test_wakeup();
        test_bypass();
        test_oldest();
        test_age_reuse();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
